serial_negate_ctrl: RTL and testbench

//  Sequencer for the serial two's-complement core (invert). Accepts a parallel word on a valid/ready

---
 rtl/sn_pkg.sv | 15 +
 rtl/serial_negate_ctrl.sv | 119 +++++++++++
 tb/tb_serial_negate_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sn_pkg.sv
// Shared types for the serial negate controller.
// Holds the sequencer state encoding and the deepest core latency supported.
package sn_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } sn_state_e;

  localparam int SN_LAT_MAX = 1;

endpackage

// File: rtl/serial_negate_ctrl.sv
// Sequencer around one serial two's-complement core: clears the core, streams a word LSB-first
// through it and reassembles the returned bits into a parallel result on a valid/ready output.
module serial_negate_ctrl
  import sn_pkg::*;
#(
  parameter int W        = 8,
  parameter int CORE_LAT = 0
) (
  input  logic         t_clock,
  input  logic         r,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_neg,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_ovf,
  output logic         ser_x,
  output logic         ser_r,
  input  logic         ser_y,
  output logic         busy
);

  localparam int CNT_W = $clog2(W + 1);

  sn_state_e            state_q, state_d;
  logic [W-1:0]         sh_q, sh_d;
  logic [W-1:0]         res_q, res_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic                 msb_q, msb_d;
  logic [SN_LAT_MAX-1:0] xd_q, xd_d;
  logic [SN_LAT_MAX-1:0] cap_q, cap_d;

  logic shifting;
  logic cap_en;
  logic x_dly;
  logic cap_bit;

  assign shifting  = (state_q == SHIFT);
  assign ser_x     = shifting ? sh_q[0] : 1'b0;
  assign ser_r     = r | (state_q == CLR);
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = out_valid ? res_q : '0;
  assign out_ovf   = out_valid & neg_q & msb_q & res_q[W-1];

  // A registered core answers one cycle late, so the echo and capture strobe are delayed to match.
  assign x_dly   = (CORE_LAT == 0) ? ser_x : xd_q[0];
  assign cap_en  = (CORE_LAT == 0) ? shifting : cap_q[0];
  assign cap_bit = neg_q ? ser_y : x_dly;

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    msb_d   = msb_q;
    xd_d    = ser_x;
    cap_d   = shifting;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sh_d    = in_data;
          neg_d   = in_neg;
          msb_d   = in_data[W-1];
          cnt_d   = '0;
          state_d = CLR;
        end
      end
      CLR: state_d = SHIFT;
      SHIFT: begin
        sh_d  = sh_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(W - 1)) begin
          state_d = (CORE_LAT == 0) ? DONE : DRAIN;
        end
      end
      DRAIN: state_d = DONE;
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (cap_en) begin
      res_d = {cap_bit, res_q[W-1:1]};
    end
  end

  always_ff @(posedge t_clock) begin
    if (r) begin
      state_q <= IDLE;
      sh_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      msb_q   <= 1'b0;
      xd_q    <= '0;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      msb_q   <= msb_d;
      xd_q    <= xd_d;
      cap_q   <= cap_d;
    end
  end

endmodule

// File: tb/tb_serial_negate_ctrl.sv
// Bench for serial_negate_ctrl: instance 0 drives a Mealy core model, instance 1 a registered one.
// A word-level model predicts handshakes, serial bits, latency and results every cycle.
module tb_serial_negate_ctrl;

  logic            clk;
  logic [1:0]      r;
  logic [1:0]      in_valid;
  logic [1:0]      in_neg;
  logic [1:0]      out_ready;
  logic [1:0][7:0] in_data;
  logic [1:0]      in_ready;
  logic [1:0]      out_valid;
  logic [1:0][7:0] out_data;
  logic [1:0]      out_ovf;
  logic [1:0]      ser_x;
  logic [1:0]      ser_r;
  logic [1:0]      ser_y;
  logic [1:0]      busy;

  int checks;
  int failures;
  int cyc;

  // word-level model state, one slot per instance
  bit        flight [2];
  int        accEdge [2];
  logic [7:0] wordIn [2];
  logic [7:0] expData [2];
  logic       expOvf [2];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    logic seenQ;
    logic yRegQ;

    serial_negate_ctrl #(.W(8), .CORE_LAT(g)) dut (
      .t_clock  (clk),
      .r        (r[g]),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .in_data  (in_data[g]),
      .in_neg   (in_neg[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out_data (out_data[g]),
      .out_ovf  (out_ovf[g]),
      .ser_x    (ser_x[g]),
      .ser_r    (ser_r[g]),
      .ser_y    (ser_y[g]),
      .busy     (busy[g])
    );

    // Serial negation: copy bits up to and including the first 1, invert all later bits.
    always @(posedge clk) begin
      if (ser_r[g]) begin
        seenQ <= 1'b0;
        yRegQ <= 1'b0;
      end else begin
        seenQ <= seenQ | ser_x[g];
        yRegQ <= ser_x[g] ^ seenQ;
      end
    end

    assign ser_y[g] = (g == 0) ? (ser_x[g] ^ seenQ) : yRegQ;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] modelResult(input logic [7:0] d, input logic n);
    int v;
    v = n ? ((256 - int'(d)) % 256) : int'(d);
    return v[7:0];
  endfunction

  // Per-cycle comparison against the word-level model.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit ev;
      int k;
      logic expX;
      if (r[i]) begin
        checkOutput($sformatf("ser_r_during_reset%0d", i), ser_r[i], 1);
        flight[i] = 0;
      end else begin
        ev = flight[i] && (cyc >= accEdge[i] + 9 + i);
        k  = cyc - accEdge[i] - 1;
        expX = (flight[i] && k >= 0 && k < 8) ? wordIn[i][k[2:0]] : 1'b0;
        checkOutput($sformatf("out_valid%0d", i), out_valid[i], ev);
        checkOutput($sformatf("in_ready%0d", i), in_ready[i], !flight[i]);
        checkOutput($sformatf("busy%0d", i), busy[i], flight[i]);
        checkOutput($sformatf("ser_r%0d", i), ser_r[i], flight[i] && cyc == accEdge[i]);
        checkOutput($sformatf("ser_x%0d", i), ser_x[i], expX);
        if (ev && out_valid[i]) begin
          checkOutput($sformatf("out_data%0d", i), out_data[i], expData[i]);
          checkOutput($sformatf("out_ovf%0d", i), out_ovf[i], expOvf[i]);
        end
        if (!flight[i]) begin
          if (in_valid[i]) begin
            flight[i]  = 1;
            accEdge[i] = cyc + 1;
            wordIn[i]  = in_data[i];
            expData[i] = modelResult(in_data[i], in_neg[i]);
            expOvf[i]  = in_neg[i] && (in_data[i] == 8'h80);
          end
        end else if (ev && out_ready[i]) begin
          flight[i] = 0;
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic applyStimulus(input int i, input logic [7:0] d, input logic n);
    int waited;
    in_valid[i] = 1'b1;
    in_data[i]  = d;
    in_neg[i]   = n;
    waited = 0;
    while (!in_ready[i] && waited < 60) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready[i]) checkOutput($sformatf("in_ready_timeout%0d", i), 0, 1);
    @(posedge clk); #1;
    in_valid[i] = 1'b0;
  endtask

  // Waits for the result, pins it to literals, stalls the consumer for hold cycles, then takes it.
  task automatic expectResult(input int i, input logic [7:0] d, input logic o, input int hold);
    int waited;
    waited = 0;
    while (!out_valid[i] && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!out_valid[i]) begin
      checkOutput($sformatf("out_valid_timeout%0d", i), 0, 1);
      return;
    end
    checkOutput($sformatf("lit_data%0d", i), out_data[i], d);
    checkOutput($sformatf("lit_ovf%0d", i), out_ovf[i], o);
    for (int h = 0; h < hold; h++) begin
      in_valid[i] = 1'b1;
      in_data[i]  = 8'hEE;
      in_neg[i]   = 1'b1;
      @(posedge clk); #1;
      checkOutput($sformatf("hold_valid%0d", i), out_valid[i], 1);
      checkOutput($sformatf("hold_data%0d", i), out_data[i], d);
      checkOutput($sformatf("hold_in_ready%0d", i), in_ready[i], 0);
    end
    in_valid[i]  = 1'b0;
    out_ready[i] = 1'b1;
    @(posedge clk); #1;
    out_ready[i] = 1'b0;
  endtask

  task automatic runWord(input int i, input logic [7:0] d, input logic n,
                         input logic [7:0] expD, input logic expO, input int hold);
    applyStimulus(i, d, n);
    expectResult(i, expD, expO, hold);
  endtask

  initial begin
    logic [7:0] rd;
    logic       rn;
    r         = 2'b11;
    in_valid  = '0;
    in_neg    = '0;
    out_ready = '0;
    in_data   = '0;
    repeat (3) @(posedge clk);
    #1;
    r = 2'b00;

    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("rst_out_valid%0d", i), out_valid[i], 0);
      checkOutput($sformatf("rst_out_data%0d", i), out_data[i], 0);
      checkOutput($sformatf("rst_out_ovf%0d", i), out_ovf[i], 0);
      checkOutput($sformatf("rst_busy%0d", i), busy[i], 0);
      checkOutput($sformatf("rst_ser_x%0d", i), ser_x[i], 0);
    end

    runWord(0, 8'h05, 1'b1, 8'hFB, 1'b0, 0);
    runWord(0, 8'h01, 1'b1, 8'hFF, 1'b0, 0);
    runWord(0, 8'h80, 1'b1, 8'h80, 1'b1, 0);
    runWord(0, 8'h00, 1'b1, 8'h00, 1'b0, 0);
    runWord(0, 8'h5A, 1'b0, 8'h5A, 1'b0, 0);
    runWord(0, 8'h80, 1'b0, 8'h80, 1'b0, 0);
    runWord(0, 8'h3C, 1'b1, 8'hC4, 1'b0, 5);
    runWord(0, 8'h03, 1'b1, 8'hFD, 1'b0, 0);
    runWord(0, 8'h7F, 1'b1, 8'h81, 1'b0, 0);

    // abort a word once four bits have gone out
    applyStimulus(0, 8'h37, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    r[0] = 1'b1;
    @(posedge clk); #1;
    r[0] = 1'b0;
    checkOutput("abort_out_valid", out_valid[0], 0);
    checkOutput("abort_busy", busy[0], 0);
    runWord(0, 8'h10, 1'b1, 8'hF0, 1'b0, 0);

    runWord(1, 8'h01, 1'b1, 8'hFF, 1'b0, 0);
    runWord(1, 8'h06, 1'b1, 8'hFA, 1'b0, 0);
    runWord(1, 8'h80, 1'b1, 8'h80, 1'b1, 2);
    runWord(1, 8'hA5, 1'b0, 8'hA5, 1'b0, 0);

    for (int i = 0; i < 2; i++) begin
      for (int n = 0; n < 25; n++) begin
        rd = 8'($urandom);
        if ($urandom_range(0, 7) == 0) rd = 8'h80;
        if ($urandom_range(0, 7) == 0) rd = 8'h00;
        rn = 1'($urandom);
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
        runWord(i, rd, rn, modelResult(rd, rn), rn && (rd == 8'h80), $urandom_range(0, 3));
      end
    end

    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
